// File: rtl/deser_pkg.sv
// Shared definitions for the serial-to-parallel deserializer: FSM state encoding and default word width.
package deser_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

`ifdef DESER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    PARITY = 2'd2
  } deser_state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1
  } deser_state_t;
`endif

endpackage

// File: rtl/shift_deserializer_if.sv
// Serial input, parallel output and status bundle for shift_deserializer.
// parity_err exists only when DESER_PARITY_EN is defined.
interface shift_deserializer_if
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic             SI;
  logic             SV;
  logic             SOF;
  logic [WIDTH-1:0] Q;
  logic             Q_valid;
  logic             Q_ready;
  logic             overrun;
  logic [CW-1:0]    bit_cnt;
`ifdef DESER_PARITY_EN
  logic             parity_err;
`endif

  modport master (
    output SI, SV, SOF, Q_ready,
`ifdef DESER_PARITY_EN
    input  parity_err,
`endif
    input  Q, Q_valid, overrun, bit_cnt
  );

  modport slave (
    input  SI, SV, SOF, Q_ready,
`ifdef DESER_PARITY_EN
    output parity_err,
`endif
    output Q, Q_valid, overrun, bit_cnt
  );

endinterface

// File: rtl/deser_bit_counter.sv
// Bit-position counter: wraps to zero on the increment at LIMIT; clear with increment restarts at one.
module deser_bit_counter #(
  parameter int unsigned LIMIT = 3,
  parameter int unsigned CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  assign tc = (cnt == CW'(LIMIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? CW'(1) : '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/shift_deserializer.sv
// MSB-first serial-to-parallel deserializer with a one-word output holding register and sticky overrun.
// Define DESER_PARITY_EN to expect an even-parity bit after each word and flag mismatches on parity_err.
module shift_deserializer
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  shift_deserializer_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
`ifdef DESER_PARITY_EN
  localparam int unsigned LIMIT = WIDTH;
`else
  localparam int unsigned LIMIT = WIDTH - 1;
`endif

  deser_state_t     state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] word;
  logic             q_valid_r;
  logic             overrun_r;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             shift;
  logic             deliver;
  logic             hs;
`ifdef DESER_PARITY_EN
  logic             parity_err_r;
`endif

  deser_bit_counter #(
    .LIMIT (LIMIT),
    .CW    (CW)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.SOF),
    .inc   (bus.SV),
    .cnt   (cnt),
    .tc    (tc)
  );

  assign hs      = q_valid_r & bus.Q_ready;
  assign deliver = bus.SV & ~bus.SOF & tc;

  // In parity mode the parity bit is not shifted in, so shreg already holds the word.
`ifdef DESER_PARITY_EN
  assign shift = bus.SV & (bus.SOF | (state != PARITY));
  assign word  = shreg;
`else
  assign shift = bus.SV;
  assign word  = {shreg[WIDTH-2:0], bus.SI};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shreg     <= '0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
      overrun_r <= 1'b0;
`ifdef DESER_PARITY_EN
      parity_err_r <= 1'b0;
`endif
    end else begin
      if (shift) begin
        shreg <= {shreg[WIDTH-2:0], bus.SI};
      end

      if (hs) begin
        q_valid_r <= 1'b0;
      end
      // A completion overrides the handshake clear; only a blocked output drops the word.
      if (deliver) begin
        if (q_valid_r && !bus.Q_ready) begin
          overrun_r <= 1'b1;
        end else begin
          q_r       <= word;
          q_valid_r <= 1'b1;
        end
      end

`ifdef DESER_PARITY_EN
      parity_err_r <= deliver & (^shreg ^ bus.SI);
`endif

      if (bus.SV) begin
        if (bus.SOF) begin
          state <= RECV;
        end else begin
          case (state)
            IDLE: state <= RECV;
`ifdef DESER_PARITY_EN
            RECV:   if (cnt == CW'(WIDTH - 1)) state <= PARITY;
            PARITY: state <= IDLE;
`else
            RECV:   if (tc) state <= IDLE;
`endif
            default: state <= IDLE;
          endcase
        end
      end else if (bus.SOF) begin
        state <= IDLE;
      end
    end
  end

  assign bus.Q       = q_r;
  assign bus.Q_valid = q_valid_r;
  assign bus.overrun = overrun_r;
  assign bus.bit_cnt = cnt;
`ifdef DESER_PARITY_EN
  assign bus.parity_err = parity_err_r;
`endif

endmodule
